// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM for the RV64 simple CPU.
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, waits on
// the memory ready handshake, traps illegal opcodes and memory timeouts into a
// sticky FAULT state, and counts retired instructions.
module multicycle_control_fsm #(
    parameter int ALU_OP_W    = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int SUPPORT_IMM = 1,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_src,
    output logic                ir_w,
    output logic                pc_w,
    output logic                pc_src,
    output logic [ALU_OP_W-1:0] ctrl_ALU_op,
    output logic                ctrl_ALU_src,
    output logic                ctrl_reg_w,
    output logic                ctrl_mem_to_reg,
    output logic                instr_done,
    output logic [CNT_W-1:0]    retired,
    output logic                fault,
    output logic [2:0]          state_o
);

    // State encoding is visible on state_o, so the values are fixed.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    // Instruction classes latched in DECODE; C_NONE only appears after reset.
    localparam logic [2:0] C_NONE   = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_R      = 3'd3;
    localparam logic [2:0] C_IMM    = 3'd4;
    localparam logic [2:0] C_BRANCH = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    logic [2:0]       state_q, state_d;
    logic [2:0]       cls_q, cls_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [2:0]       dec_cls;
    logic             dec_legal;
    logic [2:0]       done_state;
    logic [1:0]       alu_code;
    logic             exec_src;

    // Where a finished instruction goes: keep running while start is held.
    assign done_state = start ? S_FETCH : S_IDLE;

    // Classify the incoming opcode; anything unrecognised is illegal.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        dec_cls   = C_NONE;
        dec_legal = 1'b1;
        case (opcode)
            OP_LOAD:   dec_cls = C_LOAD;
            OP_STORE:  dec_cls = C_STORE;
            OP_R:      dec_cls = C_R;
            OP_BRANCH: dec_cls = C_BRANCH;
            OP_IMM: begin
                if (SUPPORT_IMM != 0) dec_cls   = C_IMM;
                else                  dec_legal = 1'b0;
            end
            default:   dec_legal = 1'b0;
        endcase
    end

    // ALU controls for the latched class; shared by EXEC and WB so WB holds them.
    always_comb begin
        alu_code = 2'b00;
        exec_src = 1'b0;
        case (cls_q)
            C_R:             alu_code = 2'b10;
            C_IMM:           begin alu_code = 2'b11; exec_src = 1'b1; end
            C_LOAD, C_STORE: begin alu_code = 2'b00; exec_src = 1'b1; end
            C_BRANCH:        alu_code = 2'b01;
            default:         alu_code = 2'b00;
        endcase
    end

    // Next-state, latched class and memory wait counter.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    wait_d  = '0;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == TIMEOUT_CNT) state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    cls_d   = dec_cls;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_R, C_IMM:      state_d = S_WB;
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH:        state_d = done_state;
                    default:         state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    wait_d  = '0;
                    state_d = (cls_q == C_STORE) ? done_state : S_WB;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == TIMEOUT_CNT) state_d = S_FAULT;
                end
            end
            S_WB:    state_d = done_state;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
        // Every fresh memory wait starts counting from zero.
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
            wait_d = '0;
        end
    end

    // Datapath controls, purely combinational from state, class and handshakes.
    always_comb begin
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        addr_src        = 1'b0;
        ir_w            = 1'b0;
        pc_w            = 1'b0;
        pc_src          = 1'b0;
        ctrl_ALU_op     = '0;
        ctrl_ALU_src    = 1'b0;
        ctrl_reg_w      = 1'b0;
        ctrl_mem_to_reg = 1'b0;
        instr_done      = 1'b0;
        fault           = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_w    = mem_ready;
                pc_w    = mem_ready;
            end
            S_EXEC: begin
                ctrl_ALU_op  = ALU_OP_W'(alu_code);
                ctrl_ALU_src = exec_src;
                if (cls_q == C_BRANCH) begin
                    pc_w       = branch_taken;
                    pc_src     = branch_taken;
                    instr_done = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                addr_src     = 1'b1;
                ctrl_ALU_op  = '0;
                ctrl_ALU_src = 1'b1;
                mem_we       = (cls_q == C_STORE);
                instr_done   = (cls_q == C_STORE) && mem_ready;
            end
            S_WB: begin
                ctrl_ALU_op     = ALU_OP_W'(alu_code);
                ctrl_ALU_src    = exec_src;
                ctrl_reg_w      = 1'b1;
                ctrl_mem_to_reg = (cls_q == C_LOAD);
                instr_done      = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: fault = 1'b0;
        endcase
    end

    // Retired count advances once per completed instruction and wraps naturally.
    assign retired_d = retired_q + CNT_W'(instr_done);

    // State, class, wait counter and retired counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every flop here is cleared by the async reset, so reset drops
        // the machine straight to IDLE and zeroes all outputs immediately.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_NONE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. An instruction-level model
// turns {opcode, branch outcome, memory delays, start} into the expected
// per-cycle control outputs; a second instance covers SUPPORT_IMM=0, a short
// timeout, a wider ALU op field and a 4-bit retired counter.
module tb_multicycle_control_fsm;

    typedef enum int {ILL, LD, ST, RR, IM, BR} cls_e;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       addr_src;
        logic       ir_w;
        logic       pc_w;
        logic       pc_src;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_w;
        logic       m2r;
        logic       done;
        logic       fault;
    } obs_t;

    typedef struct {
        logic [6:0] op;
        bit         taken;
        int         fdly;
        int         mdly;
        bit         start_end;
        logic [2:0] exp_state;
        int         exp_inc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;

    logic        d1_mem_req, d1_mem_we, d1_addr_src, d1_ir_w, d1_pc_w, d1_pc_src;
    logic [1:0]  d1_alu;
    logic        d1_src, d1_reg_w, d1_m2r, d1_done, d1_fault;
    logic [31:0] d1_ret;
    logic [2:0]  d1_state;

    logic        d2_mem_req, d2_mem_we, d2_addr_src, d2_ir_w, d2_pc_w, d2_pc_src;
    logic [2:0]  d2_alu;
    logic        d2_src, d2_reg_w, d2_m2r, d2_done, d2_fault;
    logic [3:0]  d2_ret;
    logic [2:0]  d2_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          sel2     = 1'b0;
    int          cur_tmo  = 15;
    bit          cur_imm_ok = 1'b1;
    logic [31:0] ret_mask = 32'hFFFF_FFFF;
    logic [31:0] exp_ret  = 32'd0;

    multicycle_control_fsm dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_req(d1_mem_req), .mem_we(d1_mem_we), .addr_src(d1_addr_src),
        .ir_w(d1_ir_w), .pc_w(d1_pc_w), .pc_src(d1_pc_src),
        .ctrl_ALU_op(d1_alu), .ctrl_ALU_src(d1_src), .ctrl_reg_w(d1_reg_w),
        .ctrl_mem_to_reg(d1_m2r), .instr_done(d1_done), .retired(d1_ret),
        .fault(d1_fault), .state_o(d1_state)
    );

    multicycle_control_fsm #(
        .ALU_OP_W(3), .MEM_TIMEOUT(3), .SUPPORT_IMM(0), .CNT_W(4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_req(d2_mem_req), .mem_we(d2_mem_we), .addr_src(d2_addr_src),
        .ir_w(d2_ir_w), .pc_w(d2_pc_w), .pc_src(d2_pc_src),
        .ctrl_ALU_op(d2_alu), .ctrl_ALU_src(d2_src), .ctrl_reg_w(d2_reg_w),
        .ctrl_mem_to_reg(d2_m2r), .instr_done(d2_done), .retired(d2_ret),
        .fault(d2_fault), .state_o(d2_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t actual();
        obs_t a;
        if (!sel2) begin
            a = '{d1_state, d1_mem_req, d1_mem_we, d1_addr_src, d1_ir_w, d1_pc_w,
                  d1_pc_src, {1'b0, d1_alu}, d1_src, d1_reg_w, d1_m2r, d1_done, d1_fault};
        end else begin
            a = '{d2_state, d2_mem_req, d2_mem_we, d2_addr_src, d2_ir_w, d2_pc_w,
                  d2_pc_src, d2_alu, d2_src, d2_reg_w, d2_m2r, d2_done, d2_fault};
        end
        return a;
    endfunction

    function automatic logic [31:0] act_ret();
        return sel2 ? {28'd0, d2_ret} : d1_ret;
    endfunction

    function automatic obs_t z(input logic [2:0] st);
        obs_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic cls_e classify(input logic [6:0] op);
        case (op)
            7'b0000011: return LD;
            7'b0100011: return ST;
            7'b0110011: return RR;
            7'b1100011: return BR;
            7'b0010011: return cur_imm_ok ? IM : ILL;
            default:    return ILL;
        endcase
    endfunction

    function automatic obs_t with_alu(input obs_t e, input cls_e c);
        obs_t r;
        r = e;
        case (c)
            RR:      r.alu_op = 3'd2;
            IM:      begin r.alu_op = 3'd3; r.alu_src = 1'b1; end
            LD, ST:  begin r.alu_op = 3'd0; r.alu_src = 1'b1; end
            BR:      r.alu_op = 3'd1;
            default: r.alu_op = 3'd0;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: inputs already driven; compare at the falling edge.
    task automatic cycle(input obs_t e, input string tag);
        @(negedge clk);
        check(tag, 64'(actual()), 64'(e));
        check({tag, " retired"}, 64'(act_ret()), 64'(exp_ret));
        if (e.done) exp_ret = (exp_ret + 32'd1) & ret_mask;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input bit s);
        start        = s;
        mem_ready    = 1'($urandom);
        branch_taken = 1'($urandom);
        opcode       = 7'($urandom);
        cycle(z(3'd0), "idle");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset outputs", 64'(actual()), 64'(z(3'd0)));
        check("reset retired", 64'(act_ret()), 64'd0);
        exp_ret = 32'd0;
        start   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fault_hold(input int n);
        obs_t e;
        e       = z(3'd6);
        e.fault = 1'b1;
        for (int i = 0; i < n; i++) begin
            start        = 1'(i);
            mem_ready    = 1'($urandom);
            branch_taken = 1'($urandom);
            cycle(e, "fault hold");
        end
    endtask

    // Runs one instruction starting in FETCH. outcome: 0 FETCH next, 1 IDLE next, 2 FAULT.
    task automatic run_instr(input logic [6:0] op, input bit taken, input int fdly,
                             input int mdly, input bit start_end, output int outcome);
        obs_t e;
        cls_e c;
        start = start_end;
        for (int i = 0; i <= fdly && i <= cur_tmo; i++) begin
            mem_ready    = (i == fdly);
            branch_taken = 1'($urandom);
            opcode       = 7'($urandom);
            e            = z(3'd1);
            e.mem_req    = 1'b1;
            e.ir_w       = mem_ready;
            e.pc_w       = mem_ready;
            cycle(e, "fetch");
        end
        if (fdly > cur_tmo) begin outcome = 2; return; end
        opcode       = op;
        mem_ready    = 1'($urandom);
        branch_taken = 1'($urandom);
        cycle(z(3'd2), "decode");
        c = classify(op);
        if (c == ILL) begin outcome = 2; return; end
        mem_ready    = 1'($urandom);
        branch_taken = (c == BR) ? taken : 1'($urandom);
        e = with_alu(z(3'd3), c);
        if (c == BR) begin
            e.pc_w   = taken;
            e.pc_src = taken;
            e.done   = 1'b1;
        end
        cycle(e, "exec");
        if (c == BR) begin outcome = start_end ? 0 : 1; return; end
        if (c == LD || c == ST) begin
            for (int i = 0; i <= mdly && i <= cur_tmo; i++) begin
                mem_ready    = (i == mdly);
                branch_taken = 1'($urandom);
                e            = with_alu(z(3'd4), c);
                e.mem_req    = 1'b1;
                e.addr_src   = 1'b1;
                e.mem_we     = (c == ST);
                e.done       = (c == ST) && mem_ready;
                cycle(e, "mem");
            end
            if (mdly > cur_tmo) begin outcome = 2; return; end
            if (c == ST) begin outcome = start_end ? 0 : 1; return; end
        end
        mem_ready    = 1'($urandom);
        branch_taken = 1'($urandom);
        e       = with_alu(z(3'd5), c);
        e.reg_w = 1'b1;
        e.m2r   = (c == LD);
        e.done  = 1'b1;
        cycle(e, "wb");
        outcome = start_end ? 0 : 1;
    endtask

    initial begin
        vec_t        tbl[10];
        int          outcome;
        int          st;
        logic [31:0] ret_before;
        obs_t        e;

        tbl[0] = '{7'b0110011, 1'b0, 0,  0,  1'b1, 3'd1, 1};
        tbl[1] = '{7'b0000011, 1'b0, 1,  3,  1'b1, 3'd1, 1};
        tbl[2] = '{7'b0100011, 1'b0, 0,  2,  1'b1, 3'd1, 1};
        tbl[3] = '{7'b1100011, 1'b1, 0,  0,  1'b1, 3'd1, 1};
        tbl[4] = '{7'b1100011, 1'b0, 2,  0,  1'b1, 3'd1, 1};
        tbl[5] = '{7'b0010011, 1'b0, 0,  0,  1'b1, 3'd1, 1};
        tbl[6] = '{7'b0000011, 1'b0, 15, 15, 1'b1, 3'd1, 1};
        tbl[7] = '{7'b0100011, 1'b0, 10, 15, 1'b0, 3'd0, 1};
        tbl[8] = '{7'b0110011, 1'b0, 0,  0,  1'b1, 3'd1, 1};
        tbl[9] = '{7'b1111111, 1'b0, 0,  0,  1'b1, 3'd6, 0};

        rst_n = 1'b0; start = 1'b0; opcode = '0; mem_ready = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        do_reset();
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // Table of instructions on the default-parameter instance.
        for (int i = 0; i < 10; i++) begin
            ret_before = act_ret();
            run_instr(tbl[i].op, tbl[i].taken, tbl[i].fdly, tbl[i].mdly, tbl[i].start_end, outcome);
            check($sformatf("vec%0d state_after", i), 64'(d1_state), 64'(tbl[i].exp_state));
            check($sformatf("vec%0d retired_inc", i), 64'(act_ret() - ret_before), 64'(tbl[i].exp_inc));
            if (outcome == 1) begin
                idle_cycle(1'b0);
                idle_cycle(1'b1);
            end
        end

        // FAULT is sticky while start toggles; reset clears it and the counter.
        fault_hold(6);
        do_reset();

        // FETCH timeout: 16 waiting cycles then FAULT.
        idle_cycle(1'b1);
        run_instr(7'b0110011, 1'b0, 16, 0, 1'b1, outcome);
        check("fetch timeout state", 64'(d1_state), 64'd6);
        fault_hold(3);
        do_reset();

        // Reset in the middle of a LOAD's MEM phase.
        idle_cycle(1'b1);
        run_instr(7'b0110011, 1'b0, 0, 0, 1'b1, outcome);
        start = 1'b1; mem_ready = 1'b1; opcode = 7'b0000011;
        e = z(3'd1); e.mem_req = 1'b1; e.ir_w = 1'b1; e.pc_w = 1'b1;
        cycle(e, "mr fetch");
        cycle(z(3'd2), "mr decode");
        mem_ready = 1'b0;
        cycle(with_alu(z(3'd3), LD), "mr exec");
        #1;
        check("mr mem_req pending", 64'(d1_mem_req), 64'd1);
        check("mr retired before reset", 64'(d1_ret), 64'd1);
        do_reset();

        // Randomised instruction stream against the model.
        idle_cycle(1'b1);
        st = 0;
        for (int k = 0; k < 80; k++) begin
            logic [6:0] op;
            int         r;
            int         fd;
            int         md;
            if (st == 1) begin
                repeat ($urandom_range(0, 2)) idle_cycle(1'b0);
                idle_cycle(1'b1);
            end else if (st == 2) begin
                fault_hold(2);
                do_reset();
                idle_cycle(1'b1);
            end
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    op = 7'b0000011;
                2, 3:    op = 7'b0100011;
                4, 5, 11: op = 7'b0110011;
                6, 7:    op = 7'b0010011;
                8, 9:    op = 7'b1100011;
                default: op = 7'($urandom);
            endcase
            fd = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            md = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            run_instr(op, 1'($urandom), fd, md, $urandom_range(0, 4) != 0, st);
        end

        // Second instance: 4-bit counter wrap, short timeout, no OP-IMM.
        sel2       = 1'b1;
        cur_tmo    = 3;
        cur_imm_ok = 1'b0;
        ret_mask   = 32'h0000_000F;
        do_reset();
        idle_cycle(1'b1);
        for (int i = 0; i < 17; i++) begin
            if (i == 10)
                run_instr(7'b0000011, 1'b0, 0, 3, 1'b1, outcome);
            else
                run_instr(7'b0110011, 1'b0, (i == 5) ? 3 : 0, 0, i != 16, outcome);
        end
        check("wrap retired", 64'(d2_ret), 64'd1);
        check("wrap state idle", 64'(d2_state), 64'd0);
        idle_cycle(1'b1);
        run_instr(7'b0010011, 1'b0, 0, 0, 1'b1, outcome);
        check("imm illegal state", 64'(d2_state), 64'd6);
        fault_hold(2);
        do_reset();
        idle_cycle(1'b1);
        run_instr(7'b0110011, 1'b0, 4, 0, 1'b1, outcome);
        check("short timeout state", 64'(d2_state), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
